// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX round-robin arbiter.
package uart_arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  typedef logic [7:0] byte_t;
  localparam int unsigned UART_ARB_NUM_REQ_DEF   = 4;
  localparam int unsigned UART_ARB_BURST_MAX_DEF = 64;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot first request above last_grant, wrapping.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [N-1:0]         pick
);
  localparam int unsigned W = $clog2(N);

  always_comb begin
    int unsigned idx;
    logic        found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last_grant) + i) % N;
      if (!found && req[idx[W-1:0]]) begin
        pick[idx[W-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// Frame-atomic round-robin arbiter sharing one UART TX byte channel.
// Optional per-grant beat limit: define UART_ARB_BURST_LIMIT_EN.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = UART_ARB_NUM_REQ_DEF,
  parameter int unsigned BURST_MAX = UART_ARB_BURST_MAX_DEF
) (
  input  logic                 clk100,
  input  logic                 rstn,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);
  localparam int unsigned GW = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, pick;
  logic [GW-1:0]      last_q, last_d, pick_idx;
  logic               own_valid, own_last, accept, burst_hit;
  byte_t              own_data;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req        (req_valid_i),
    .last_grant (last_q),
    .pick       (pick)
  );

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    pick_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        own_valid = req_valid_i[k];
        own_last  = req_last_i[k];
        own_data  = req_data_i[8*k +: 8];
      end
      if (pick[k]) pick_idx = GW'(k);
    end
  end

  assign accept = own_valid & tx_ready_i;

`ifdef UART_ARB_BURST_LIMIT_EN
  logic [7:0] cnt_q, cnt_d;

  // The beat that brings the count to BURST_MAX is the final one of this grant.
  assign burst_hit = (cnt_q == 8'(BURST_MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)  cnt_d = '0;
    else if (accept)      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign burst_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          state_d = GRANT;
          grant_d = pick;
          last_d  = pick_idx;
        end
      end
      GRANT: begin
        if (accept && (own_last || burst_hit)) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign busy_o      = (state_q == GRANT);
  assign grant_o     = grant_q;
  assign tx_valid_o  = own_valid & busy_o;
  assign tx_data_o   = tx_valid_o ? own_data : 8'h00;
  assign req_ready_o = grant_q & {NUM_REQ{tx_ready_i}};
endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: per-requester stream drivers, negedge monitor.
module tb_uart_tx_arb;
  localparam int NR = 4;

  logic            clk100 = 1'b0;
  logic            rstn;
  logic [NR-1:0]   req_valid_i;
  logic [NR*8-1:0] req_data_i;
  logic [NR-1:0]   req_last_i;
  logic [NR-1:0]   req_ready_o;
  logic            tx_valid_o;
  logic [7:0]      tx_data_o;
  logic            tx_ready_i;
  logic [NR-1:0]   grant_o;
  logic            busy_o;

  uart_tx_arb #(.NUM_REQ(NR), .BURST_MAX(4)) dut (
    .clk100      (clk100),
    .rstn        (rstn),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk100 = ~clk100;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  always @(posedge clk100) cyc++;

  logic [7:0] dq [NR][$];
  bit         lq [NR][$];
  logic [7:0] exp_d [$];
  int         exp_id [$];
  int         log_cyc [$];
  int         log_id [$];
  logic [NR-1:0] acc_s = '0;
  bit         tgl = 1'b0;
  bit         stall_pend = 1'b0;
  logic [7:0] stall_d = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_push(input int k, input logic [7:0] d);
    exp_id.push_back(k);
    exp_d.push_back(d);
  endtask

  task automatic push_frame(input int k, input logic [7:0] base, input int n, input bit with_exp);
    for (int i = 0; i < n; i++) begin
      dq[k].push_back(base + 8'(i));
      lq[k].push_back(i == n - 1);
      if (with_exp) exp_push(k, base + 8'(i));
    end
  endtask

  // Stream driver: retire beats accepted in the previous cycle, present the next ones.
  always @(negedge clk100) acc_s = req_valid_i & req_ready_o;

  initial begin
    logic [7:0] dmy;
    bit         lmy;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    tx_ready_i  = 1'b1;
    forever begin
      @(posedge clk100);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (acc_s[k] && dq[k].size() > 0) begin
          dmy = dq[k].pop_front();
          lmy = lq[k].pop_front();
        end
        req_valid_i[k]        = (dq[k].size() > 0);
        req_data_i[8*k +: 8]  = (dq[k].size() > 0) ? dq[k][0] : 8'h00;
        req_last_i[k]         = (dq[k].size() > 0) ? lq[k][0] : 1'b0;
      end
      tx_ready_i = tgl ? ~tx_ready_i : 1'b1;
    end
  end

  // Monitor: protocol invariants every cycle, scoreboard on each accepted byte.
  always @(negedge clk100) begin
    if (!rstn) begin
      stall_pend = 1'b0;
    end else begin
      check("ready_mirror", 32'(req_ready_o), 32'(grant_o & {NR{tx_ready_i}}));
      check("busy_vs_grant", 32'(busy_o), 32'(|grant_o));
      check("valid_vs_owner", 32'(tx_valid_o), 32'(|(grant_o & req_valid_i)));
      if (!tx_valid_o) check("data_zero_idle", 32'(tx_data_o), 32'h0);
      if (stall_pend && tx_valid_o) check("stall_hold", 32'(tx_data_o), 32'(stall_d));
      stall_pend = tx_valid_o && !tx_ready_i;
      stall_d    = tx_data_o;
      if (tx_valid_o && tx_ready_i) begin
        if (exp_d.size() == 0) begin
          check("unexpected_byte", 32'(tx_data_o), 32'hFFFF_FFFF);
        end else begin
          int         id;
          logic [7:0] d;
          id = exp_id.pop_front();
          d  = exp_d.pop_front();
          check("sb_grant", 32'(grant_o), 32'(1) << id);
          check("sb_data", 32'(tx_data_o), 32'(d));
          log_cyc.push_back(cyc);
          log_id.push_back(id);
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int  n;
    bit  busy_q;
    n = 0;
    do begin
      @(negedge clk100);
      #1;
      busy_q = (exp_d.size() > 0);
      for (int k = 0; k < NR; k++) if (dq[k].size() > 0) busy_q = 1'b1;
      n++;
    end while (busy_q && n < budget);
    if (busy_q) begin
      ntests++;
      nfail++;
      $display("FAIL %s: drain timeout, %0d bytes still expected, required 0", name, exp_d.size());
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_grant"}, 32'(grant_o), 32'h0);
    check({name, "_txv"},   32'(tx_valid_o), 32'h0);
    check({name, "_txd"},   32'(tx_data_o), 32'h0);
    check({name, "_rdy"},   32'(req_ready_o), 32'h0);
    check({name, "_busy"},  32'(busy_o), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk100);
    rstn = 1'b0;
    repeat (2) @(negedge clk100);
    rstn = 1'b1;
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    repeat (3) @(negedge clk100);
    check_idle_outputs("reset");
    rstn = 1'b1;
    @(negedge clk100);
    check_idle_outputs("post_reset");

    // 3-byte frame from requester 0: grant one cycle after valid, back-to-back bytes.
    log_cyc.delete(); log_id.delete();
    push_frame(0, 8'h41, 3, 1'b1);
    @(negedge clk100);
    n = cyc;
    check("t1_grant_pre", 32'(grant_o), 32'h0);
    @(negedge clk100);
    check("t1_grant", 32'(grant_o), 32'b0001);
    check("t1_first_byte", 32'(tx_data_o), 32'h41);
    wait_drain("t1", 50);
    check("t1_cyc0", 32'(log_cyc[0]), 32'(n + 1));
    check("t1_cyc2", 32'(log_cyc[2]), 32'(n + 3));
    @(negedge clk100);
    check("t1_idle_after", 32'(busy_o), 32'h0);

    // Four 1-byte frames: round-robin 0..3, new grant every 2 cycles.
    do_reset();
    log_cyc.delete(); log_id.delete();
    @(negedge clk100);
    for (int k = 0; k < NR; k++) push_frame(k, 8'hA0 + 8'(k), 1, 1'b1);
    wait_drain("t2", 50);
    check("t2_count", 32'(log_id.size()), 32'd4);
    for (int i = 0; i < 3; i++) check("t2_spacing", 32'(log_cyc[i+1] - log_cyc[i]), 32'd2);

    // Requester 0 waits while requester 2 is mid-frame.
    log_cyc.delete(); log_id.delete();
    @(negedge clk100);
    push_frame(2, 8'hB0, 3, 1'b1);
    @(negedge clk100);
    @(negedge clk100);
    push_frame(0, 8'hC0, 1, 1'b1);
    @(negedge clk100);
    check("t3_owner_kept", 32'(grant_o), 32'b0100);
    check("t3_req0_stalled", 32'(req_ready_o[0]), 32'h0);
    wait_drain("t3", 50);
    check("t3_handover", 32'(log_cyc[3] - log_cyc[2]), 32'd2);

    // Backpressure toggling: no duplicate/drop, data held while stalled.
    log_cyc.delete(); log_id.delete();
    tgl = 1'b1;
    @(negedge clk100);
    push_frame(1, 8'hD0, 3, 1'b1);
    wait_drain("t4", 60);
    tgl = 1'b0;
    check("t4_count", 32'(log_id.size()), 32'd3);
    repeat (2) @(negedge clk100);

    // Reset during 2nd byte of requester 3's frame; requester 0 wins afterwards.
    log_cyc.delete(); log_id.delete();
    push_frame(3, 8'hE0, 3, 1'b0);
    exp_push(3, 8'hE0);
    repeat (2) @(negedge clk100);
    @(posedge clk100);
    #3;
    check("t5_mid_frame", 32'(tx_data_o), 32'hE1);
    check("t5_owner", 32'(grant_o), 32'b1000);
    rstn = 1'b0;
    #1;
    check_idle_outputs("t5_async");
    push_frame(0, 8'hF0, 1, 1'b0);
    exp_push(0, 8'hF0);
    exp_push(3, 8'hE1);
    exp_push(3, 8'hE2);
    repeat (2) @(negedge clk100);
    rstn = 1'b1;
    wait_drain("t5", 50);
    check("t5_first_after", 32'(log_id[1]), 32'd0);

`ifdef UART_ARB_BURST_LIMIT_EN
    // Burst limit 4: requester 1 is preempted every 4 beats.
    log_cyc.delete(); log_id.delete();
    @(negedge clk100);
    push_frame(1, 8'h10, 10, 1'b0);
    push_frame(2, 8'h60, 2, 1'b0);
    for (int i = 0; i < 4; i++) exp_push(1, 8'h10 + 8'(i));
    exp_push(2, 8'h60);
    exp_push(2, 8'h61);
    for (int i = 4; i < 10; i++) exp_push(1, 8'h10 + 8'(i));
    wait_drain("t6", 100);
    check("t6_count", 32'(log_id.size()), 32'd12);
    check("t6_switch_gap", 32'(log_cyc[4] - log_cyc[3]), 32'd2);
`endif

    repeat (2) @(negedge clk100);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one UART transmit byte channel between up to `NUM_REQ` requesters (PS mailbox, debug monitor, LED status reporter). It sits between the requester byte streams and the PL UART TX serializer/FIFO in the `clk100` domain. Once granted, a requester keeps the channel for a whole frame (through its `last` beat), so messages never interleave on the wire.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `BURST_MAX`, 64, max accepted beats per grant before forced release (used only with `UART_ARB_BURST_LIMIT_EN`)

Ports:
- `clk100` in 1: sole clock, 100 MHz
- `rstn` in 1: asynchronous, active-low reset
- `req_valid_i` in `NUM_REQ`: per-requester byte valid
- `req_data_i` in `NUM_REQ*8`: packed bytes; requester k is `[8k+7:8k]`
- `req_last_i` in `NUM_REQ`: final byte of frame
- `req_ready_o` out `NUM_REQ`: byte accepted when `valid & ready`
- `tx_valid_o` out 1: byte to UART TX
- `tx_data_o` out 8: byte to UART TX
- `tx_ready_i` in 1: UART TX can accept
- `grant_o` out `NUM_REQ`: one-hot current owner, 0 when idle
- `busy_o` out 1: high in GRANT

## Operation
- FSM states:
  - IDLE: if any `req_valid_i`, register the winner into `grant_o` and go to GRANT.
  - GRANT: on an accepted beat with `req_last_i` of the owner, clear `grant_o` and return to IDLE.
- Winner: first asserted valid searching upward from `last_grant+1`, wrapping modulo `NUM_REQ`. `last_grant` resets to `NUM_REQ-1`, so requester 0 has first priority after reset.
- Datapath in GRANT is combinational pass-through for owner g:
  - `tx_valid_o = req_valid_i[g]`
  - `tx_data_o = req_data_i[g]`
  - `req_ready_o[g] = tx_ready_i`
  - All other `req_ready_o` bits are 0.
- In IDLE, `tx_valid_o` and all `req_ready_o` bits are 0. `tx_data_o` is 0 whenever `tx_valid_o` is 0.
- If the owner drops valid mid-frame, the grant is held indefinitely (unless burst limit is enabled).
- Requests arriving during GRANT wait. They are arbitrated in the next IDLE cycle.
- Requesters obey stream rules: once valid is high, data and last are held until accepted.
- `busy_o` equals (state == GRANT).

## Timing
- Reset values: `grant_o`=0, `tx_valid_o`=0, `tx_data_o`=0, `req_ready_o`=0, `busy_o`=0, state IDLE.
- Requester valid in cycle N while IDLE produces grant and `tx_valid_o` in N+1. First possible accept is N+1.
- Throughput within a frame: 1 byte/cycle when `tx_ready_i` is held high.
- Handover: the last beat accepted in cycle M gives IDLE in M+1 and the new grant in M+2, a 2-cycle gap between frames.
- A 1-byte frame (`last` on the first beat) is legal: GRANT lasts exactly one accepted beat.
- Asserting `rstn` low mid-frame aborts immediately. An unaccepted byte is not lost (requester still holds it). After reset release, arbitration restarts from requester 0.

## Configuration
- Macro: `UART_ARB_BURST_LIMIT_EN`.
- When defined, an 8-bit beat counter clears on grant and counts accepted beats. When the count reaches `BURST_MAX` without `last`, the block forces IDLE after that beat; the frame resumes on a later grant.
- When not defined, there is no counter and a grant ends only on `last`.

## Structure
- Package `uart_arb_pkg` holds:
  - `arb_state_t` enum {IDLE, GRANT}
  - `byte_t` (logic [7:0])
  - `UART_ARB_NUM_REQ_DEF` = 4
  - `UART_ARB_BURST_MAX_DEF` = 64
- Sub-module `rr_pick` is the purely combinational round-robin picker, with inputs `req`, `last_grant` and output one-hot `pick`. Everything else lives in `uart_tx_arb`.

## Test plan
- Reset, then `req_valid_i`=4'b0001 with 3-byte frame 0x41,0x42,0x43 and `tx_ready_i`=1 -> `grant_o`=0001 one cycle later; bytes appear on consecutive cycles; IDLE after 0x43.
- All four requesters valid with 1-byte frames -> grants in order 0,1,2,3, each separated by a 2-cycle gap.
- Requester 2 mid-frame while requester 0 asserts valid -> requester 0 is stalled (`req_ready_o[0]`=0) until requester 2's `last`, then is granted.
- `tx_ready_i` toggling 1,0,1,0 -> `req_ready_o[g]` mirrors it; no byte is duplicated or dropped; `tx_data_o` is stable while stalled.
- `rstn` pulsed low during the 2nd byte of a frame from requester 3 -> all outputs 0 asynchronously; requester 0 wins first when both 0 and 3 are valid after release.
- With `UART_ARB_BURST_LIMIT_EN`, `BURST_MAX`=4, requester 1 sending 10 bytes with requester 2 waiting -> grant switches to 2 after 4 bytes, then back to 1.
